// File: rtl/wifi_tx_frame_scheduler_pkg.sv
// ============================================================================
// wifi_tx_frame_scheduler_pkg
// Shared types for the Wi-Fi TX frame scheduler: FSM states and queue owner.
// Revision: 1.0
// ============================================================================
`default_nettype none

package wifi_tx_frame_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4
    } sched_state_t;

    typedef enum logic {
        OWNER_CTRL = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    localparam int REQ_CTRL_IDX = 0;
    localparam int REQ_DATA_IDX = 1;

endpackage

`default_nettype wire

// File: rtl/wifi_tx_frame_scheduler_arbiter.sv
// ============================================================================
// wifi_tx_sched_arbiter
// Control-priority arbiter; data wins once control has used its run budget.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wifi_tx_sched_arbiter
    import wifi_tx_frame_scheduler_pkg::*;
#(
    parameter int MAX_CTRL_RUN = 4,
    parameter int RUN_WIDTH    = 3
) (
    input  logic [1:0]           reqs,
    input  logic [RUN_WIDTH-1:0] ctrl_run,
    output owner_t               winner
);

    logic w_ctrl_starved_data;

    assign w_ctrl_starved_data = (ctrl_run == RUN_WIDTH'(MAX_CTRL_RUN));

    always_comb begin
        winner = OWNER_CTRL;
        if (reqs[REQ_DATA_IDX] && (!reqs[REQ_CTRL_IDX] || w_ctrl_starved_data)) begin
            winner = OWNER_DATA;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wifi_tx_frame_scheduler.sv
// ============================================================================
// wifi_tx_frame_scheduler
// Grants control/data frames, streams their words to the serializer, enforces IFS.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wifi_tx_frame_scheduler
    import wifi_tx_frame_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int SIZE_WIDTH   = 16,
    parameter int IFS_CYCLES   = 16,
    parameter int MAX_CTRL_RUN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_ctrl,
    input  logic                  req_data,
    input  logic [SIZE_WIDTH-1:0] size_ctrl,
    input  logic [SIZE_WIDTH-1:0] size_data,
    output logic                  gnt_ctrl,
    output logic                  gnt_data,
    output logic                  rd_ctrl,
    output logic                  rd_data,
    input  logic [DATA_WIDTH-1:0] rdata_ctrl,
    input  logic [DATA_WIDTH-1:0] rdata_data,
    input  logic                  abort,
    output logic                  ser_valid,
    output logic [DATA_WIDTH-1:0] ser_data,
    output logic [5:0]            ser_nbits,
    output logic                  ser_last,
    input  logic                  ser_word_done,
    output logic                  busy,
    output logic                  owner,
    output logic                  frame_done
);

    localparam int RUN_W = $clog2(MAX_CTRL_RUN + 1);
    localparam int GAP_W = $clog2(IFS_CYCLES + 1);

    sched_state_t          state_q, state_d;
    logic [SIZE_WIDTH-1:0] rem_q, rem_d;
    logic [RUN_W-1:0]      ctrl_run_q, ctrl_run_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    owner_t                owner_q, owner_d;
    logic                  gnt_ctrl_q, gnt_ctrl_d;
    logic                  gnt_data_q, gnt_data_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_WIDTH-1:0] ser_data_q, ser_data_d;
    logic [5:0]            ser_nbits_q, ser_nbits_d;
    logic                  ser_last_q, ser_last_d;

    owner_t                w_winner;
    logic                  w_req_any;
    logic [SIZE_WIDTH-1:0] w_size_sel;
    logic [DATA_WIDTH-1:0] w_rdata_sel;
    logic [5:0]            w_word_nbits;
    logic                  w_word_last;
    logic [SIZE_WIDTH-1:0] w_sent_bits;
    logic                  w_ser_valid;

    wifi_tx_sched_arbiter #(
        .MAX_CTRL_RUN (MAX_CTRL_RUN),
        .RUN_WIDTH    (RUN_W)
    ) u_arbiter (
        .reqs     ({req_data, req_ctrl}),
        .ctrl_run (ctrl_run_q),
        .winner   (w_winner)
    );

    assign w_req_any   = req_ctrl | req_data;
    assign w_size_sel  = (w_winner == OWNER_DATA) ? size_data : size_ctrl;
    assign w_rdata_sel = (owner_q == OWNER_DATA) ? rdata_data : rdata_ctrl;
    assign w_word_last = (rem_q <= SIZE_WIDTH'(DATA_WIDTH));
    assign w_word_nbits = w_word_last ? rem_q[5:0] : 6'(DATA_WIDTH);
    assign w_sent_bits = SIZE_WIDTH'(ser_nbits_q);

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        ctrl_run_d   = ctrl_run_q;
        gap_d        = '0;
        owner_d      = owner_q;
        gnt_ctrl_d   = 1'b0;
        gnt_data_d   = 1'b0;
        frame_done_d = 1'b0;
        ser_data_d   = ser_data_q;
        ser_nbits_d  = ser_nbits_q;
        ser_last_d   = ser_last_q;
        w_ser_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_req_any) begin
                    owner_d = w_winner;
                    rem_d   = w_size_sel;
                    if (w_winner == OWNER_DATA) begin
                        gnt_data_d = 1'b1;
                        ctrl_run_d = '0;
                    end else begin
                        gnt_ctrl_d = 1'b1;
                        if (ctrl_run_q != RUN_W'(MAX_CTRL_RUN)) begin
                            ctrl_run_d = ctrl_run_q + RUN_W'(1);
                        end
                    end
                    // Zero-length frames complete at grant without touching the queue.
                    if (w_size_sel == '0) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_GAP;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                state_d = abort ? ST_GAP : ST_LOAD;
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_GAP;
                end else begin
                    w_ser_valid = 1'b1;
                    ser_data_d  = w_rdata_sel;
                    ser_nbits_d = w_word_nbits;
                    ser_last_d  = w_word_last;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_GAP;
                end else if (ser_word_done) begin
                    rem_d = (rem_q > w_sent_bits) ? (rem_q - w_sent_bits) : '0;
                    if (ser_last_q) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_GAP;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(IFS_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            ctrl_run_q   <= '0;
            gap_q        <= '0;
            owner_q      <= OWNER_CTRL;
            gnt_ctrl_q   <= 1'b0;
            gnt_data_q   <= 1'b0;
            frame_done_q <= 1'b0;
            ser_data_q   <= '0;
            ser_nbits_q  <= '0;
            ser_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            ctrl_run_q   <= ctrl_run_d;
            gap_q        <= gap_d;
            owner_q      <= owner_d;
            gnt_ctrl_q   <= gnt_ctrl_d;
            gnt_data_q   <= gnt_data_d;
            frame_done_q <= frame_done_d;
            ser_data_q   <= ser_data_d;
            ser_nbits_q  <= ser_nbits_d;
            ser_last_q   <= ser_last_d;
        end
    end

    // The LOAD word bypasses the holding registers so the serializer sees it two cycles after word_done.
    assign ser_valid  = w_ser_valid;
    assign ser_data   = w_ser_valid ? w_rdata_sel  : ser_data_q;
    assign ser_nbits  = w_ser_valid ? w_word_nbits : ser_nbits_q;
    assign ser_last   = w_ser_valid ? w_word_last  : ser_last_q;

    assign rd_ctrl    = (state_q == ST_FETCH) && (owner_q == OWNER_CTRL);
    assign rd_data    = (state_q == ST_FETCH) && (owner_q == OWNER_DATA);
    assign gnt_ctrl   = gnt_ctrl_q;
    assign gnt_data   = gnt_data_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);
    assign owner      = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_wifi_tx_frame_scheduler.sv
// ============================================================================
// tb_wifi_tx_frame_scheduler
// Scoreboard bench: stimulus queues expected grant/word/done events, monitor compares.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wifi_tx_frame_scheduler;

    localparam int DW   = 32;
    localparam int SW   = 16;
    localparam int IFS  = 16;
    localparam int MAXR = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_ctrl = 1'b0, req_data = 1'b0;
    logic [SW-1:0] size_ctrl = '0, size_data = '0;
    logic          gnt_ctrl, gnt_data, rd_ctrl, rd_data;
    logic [DW-1:0] rdata_ctrl = '0, rdata_data = '0;
    logic          abort = 1'b0;
    logic          ser_valid;
    logic [DW-1:0] ser_data;
    logic [5:0]    ser_nbits;
    logic          ser_last;
    logic          ser_word_done = 1'b0;
    logic          busy, owner, frame_done;

    always #5 clk = ~clk;

    wifi_tx_frame_scheduler #(
        .DATA_WIDTH   (DW),
        .SIZE_WIDTH   (SW),
        .IFS_CYCLES   (IFS),
        .MAX_CTRL_RUN (MAXR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_ctrl      (req_ctrl),
        .req_data      (req_data),
        .size_ctrl     (size_ctrl),
        .size_data     (size_data),
        .gnt_ctrl      (gnt_ctrl),
        .gnt_data      (gnt_data),
        .rd_ctrl       (rd_ctrl),
        .rd_data       (rd_data),
        .rdata_ctrl    (rdata_ctrl),
        .rdata_data    (rdata_data),
        .abort         (abort),
        .ser_valid     (ser_valid),
        .ser_data      (ser_data),
        .ser_nbits     (ser_nbits),
        .ser_last      (ser_last),
        .ser_word_done (ser_word_done),
        .busy          (busy),
        .owner         (owner),
        .frame_done    (frame_done)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
        logic [5:0]  nbits;
        logic        last;
    } ev_t;

    localparam logic [1:0] EV_GNT  = 2'd0;
    localparam logic [1:0] EV_SER  = 2'd1;
    localparam logic [1:0] EV_DONE = 2'd2;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  ctrl_idx = 0;
    int  data_idx = 0;
    int  rd_total = 0;

    function automatic ev_t mk(logic [1:0] k, logic [31:0] d, logic [5:0] nb, logic l);
        ev_t e;
        e.kind  = k;
        e.data  = d;
        e.nbits = nb;
        e.last  = l;
        return e;
    endfunction

    function automatic void push_ev(logic [1:0] k, logic [31:0] d, logic [5:0] nb, logic l);
        exp_q.push_back(mk(k, d, nb, l));
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    function automatic void observe(ev_t got);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d data=%h nbits=%0d last=%0b, required no event",
                     got.kind, got.data, got.nbits, got.last);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_bad++;
                $display("FAIL event_mismatch: got kind=%0d data=%h nbits=%0d last=%0b, required kind=%0d data=%h nbits=%0d last=%0b",
                         got.kind, got.data, got.nbits, got.last, e.kind, e.data, e.nbits, e.last);
            end
        end
    endfunction

    function automatic logic [31:0] cw(int i);
        return 32'hC000_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] dw(int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    // Queue model: a word becomes valid the cycle after its read strobe.
    always @(negedge clk) begin
        if (rd_ctrl) begin
            rdata_ctrl = cw(ctrl_idx);
            ctrl_idx++;
            rd_total++;
        end
        if (rd_data) begin
            rdata_data = dw(data_idx);
            data_idx++;
            rd_total++;
        end
    end

    // Monitor: every DUT output event is matched against the expected queue.
    always @(negedge clk) begin
        if (gnt_ctrl)   observe(mk(EV_GNT, 32'd0, 6'd0, 1'b0));
        if (gnt_data)   observe(mk(EV_GNT, 32'd1, 6'd0, 1'b0));
        if (ser_valid)  observe(mk(EV_SER, ser_data, ser_nbits, ser_last));
        if (frame_done) observe(mk(EV_DONE, 32'd0, 6'd0, 1'b0));
    end

    task automatic wait_gnt();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt_ctrl || gnt_data) && n < 64);
        if (!(gnt_ctrl || gnt_data)) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_sv(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ser_valid && n < 64);
        if (!ser_valid) check("ser_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        ser_word_done = 1'b1;
        @(negedge clk);
        ser_word_done = 1'b0;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_gnt"},   {30'd0, gnt_ctrl, gnt_data}, 32'd0);
        check({tag, "_rd"},    {30'd0, rd_ctrl, rd_data}, 32'd0);
        check({tag, "_sv"},    {31'd0, ser_valid}, 32'd0);
        check({tag, "_data"},  ser_data, 32'd0);
        check({tag, "_nbits"}, {26'd0, ser_nbits}, 32'd0);
        check({tag, "_last"},  {31'd0, ser_last}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_owner"}, {31'd0, owner}, 32'd0);
        check({tag, "_fdone"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        int rd_snap;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // 80-bit control frame: 32, 32, 16 bits.
        push_ev(EV_GNT, 32'd0, 6'd0, 1'b0);
        push_ev(EV_SER, cw(0), 6'd32, 1'b0);
        push_ev(EV_SER, cw(1), 6'd32, 1'b0);
        push_ev(EV_SER, cw(2), 6'd16, 1'b1);
        push_ev(EV_DONE, 32'd0, 6'd0, 1'b0);
        req_ctrl  = 1'b1;
        size_ctrl = 16'd80;
        wait_gnt();
        req_ctrl = 1'b0;
        check("busy_after_gnt", {31'd0, busy}, 32'd1);
        wait_sv(n);
        check("first_word_latency", 32'(n), 32'd1);
        pulse_done();
        wait_sv(n);
        check("word_to_word_latency", 32'(n + 1), 32'd2);
        pulse_done();
        wait_sv(n);
        pulse_done();
        check("frame_done_latency", {31'd0, frame_done}, 32'd1);
        wait_idle();

        // Single full word, then a zero-length data frame.
        push_ev(EV_GNT, 32'd0, 6'd0, 1'b0);
        push_ev(EV_SER, cw(3), 6'd32, 1'b1);
        push_ev(EV_DONE, 32'd0, 6'd0, 1'b0);
        req_ctrl  = 1'b1;
        size_ctrl = 16'd32;
        wait_gnt();
        req_ctrl = 1'b0;
        wait_sv(n);
        pulse_done();
        wait_idle();

        push_ev(EV_GNT, 32'd1, 6'd0, 1'b0);
        push_ev(EV_DONE, 32'd0, 6'd0, 1'b0);
        req_data  = 1'b1;
        size_data = 16'd0;
        wait_gnt();
        req_data = 1'b0;
        check("zero_size_done_with_gnt", {31'd0, frame_done}, 32'd1);
        wait_idle();
        check("zero_size_no_read", 32'(data_idx), 32'd0);

        // Both queues requesting: four control grants, then data, then control.
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                push_ev(EV_GNT, 32'd1, 6'd0, 1'b0);
                push_ev(EV_SER, dw(0), 6'd32, 1'b1);
            end else begin
                push_ev(EV_GNT, 32'd0, 6'd0, 1'b0);
                push_ev(EV_SER, cw((i < 4) ? 4 + i : 8), 6'd32, 1'b1);
            end
            push_ev(EV_DONE, 32'd0, 6'd0, 1'b0);
        end
        req_ctrl  = 1'b1;
        req_data  = 1'b1;
        size_ctrl = 16'd32;
        size_data = 16'd32;
        for (int i = 0; i < 6; i++) begin
            wait_sv(n);
            if (i == 5) begin
                req_ctrl = 1'b0;
                req_data = 1'b0;
            end
            pulse_done();
        end
        wait_idle();

        // Spurious word_done in IDLE and in FETCH must be ignored.
        ser_word_done = 1'b1;
        @(negedge clk);
        ser_word_done = 1'b0;
        check("spurious_idle_busy", {31'd0, busy}, 32'd0);
        push_ev(EV_GNT, 32'd1, 6'd0, 1'b0);
        push_ev(EV_SER, dw(1), 6'd32, 1'b0);
        push_ev(EV_SER, dw(2), 6'd32, 1'b1);
        push_ev(EV_DONE, 32'd0, 6'd0, 1'b0);
        req_data  = 1'b1;
        size_data = 16'd64;
        wait_gnt();
        req_data      = 1'b0;
        ser_word_done = 1'b1;
        @(negedge clk);
        ser_word_done = 1'b0;
        check("spurious_fetch_still_loads", {31'd0, ser_valid}, 32'd1);
        pulse_done();
        wait_sv(n);
        pulse_done();
        check("two_word_frame_done", {31'd0, frame_done}, 32'd1);
        wait_idle();

        // Abort in SHIFT of word 2 of a 96-bit frame.
        push_ev(EV_GNT, 32'd0, 6'd0, 1'b0);
        push_ev(EV_SER, cw(9), 6'd32, 1'b0);
        push_ev(EV_SER, cw(10), 6'd32, 1'b0);
        req_ctrl  = 1'b1;
        size_ctrl = 16'd96;
        wait_gnt();
        req_ctrl = 1'b0;
        wait_sv(n);
        pulse_done();
        wait_sv(n);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        rd_snap = rd_total;
        check("abort_gap_start_busy", {31'd0, busy}, 32'd1);
        repeat (IFS - 1) @(negedge clk);
        check("abort_gap_end_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("abort_back_to_idle", {31'd0, busy}, 32'd0);
        check("abort_no_extra_read", 32'(rd_total), 32'(rd_snap));

        // Asynchronous reset in SHIFT of a data frame, then a pending control request.
        push_ev(EV_GNT, 32'd1, 6'd0, 1'b0);
        push_ev(EV_SER, dw(3), 6'd32, 1'b0);
        req_data  = 1'b1;
        size_data = 16'd64;
        wait_gnt();
        req_data = 1'b0;
        wait_sv(n);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        req_ctrl  = 1'b1;
        size_ctrl = 16'd32;
        push_ev(EV_GNT, 32'd0, 6'd0, 1'b0);
        push_ev(EV_SER, cw(11), 6'd32, 1'b1);
        push_ev(EV_DONE, 32'd0, 6'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        wait_gnt();
        req_ctrl = 1'b0;
        wait_sv(n);
        pulse_done();
        check("post_reset_frame_done", {31'd0, frame_done}, 32'd1);
        wait_idle();

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wifi_tx_frame_scheduler.md
WIFI_TX_FRAME_SCHEDULER -- requirements
Module: wifi_tx_frame_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, 32, serializer word width in bits.
REQ-002 Parameter SIZE_WIDTH, 16, width of frame-length fields, in bits.
REQ-003 Parameter IFS_CYCLES, 16, idle gap between frames, in clock cycles.
REQ-004 Parameter MAX_CTRL_RUN, 4, consecutive control grants allowed before a pending data frame wins.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req_ctrl / req_data  input  1 each  frame request from control queue / data queue; held until granted.
REQ-008 size_ctrl / size_data  input  SIZE_WIDTH each  frame length in bits; sampled at grant.
REQ-009 gnt_ctrl / gnt_data  output  1 each  one-cycle grant pulse.
REQ-010 rd_ctrl / rd_data  output  1 each  one-cycle word read strobe to the owning queue.
REQ-011 rdata_ctrl / rdata_data  input  DATA_WIDTH each  queue word, valid the cycle after the matching read strobe.
REQ-012 abort  input  1  synchronous request to drop the current frame.
REQ-013 ser_valid  output  1  one-cycle load strobe to serializer.
REQ-014 ser_data  output  DATA_WIDTH  word presented with ser_valid.
REQ-015 ser_nbits  output  6  valid bits in ser_data (1..DATA_WIDTH).
REQ-016 ser_last  output  1  marks the final word of a frame, qualified by ser_valid.
REQ-017 ser_word_done  input  1  serializer finished shifting the current word (single-cycle pulse).
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 owner  output  1  0 = control, 1 = data; valid while busy.
REQ-020 frame_done  output  1  one-cycle pulse after the last word's ser_word_done.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, LOAD, SHIFT, GAP.
REQ-022 IDLE: if any request with nonzero size, SHALL grant in the same cycle it is seen (gnt registered, asserted next cycle), latch size into remaining-bit counter, go FETCH; requests of size 0 SHALL be granted and immediately complete (frame_done pulse, no ser_valid), then go GAP.
REQ-023 Arbitration: control SHALL win when both request, unless ctrl_run counter equals MAX_CTRL_RUN and req_data is high, in which case data wins; ctrl_run increments per control grant, clears on any data grant, saturates.
REQ-024 FETCH: assert owning rd strobe one cycle, go LOAD.
REQ-025 LOAD: capture rdata of owner, drive ser_valid one cycle with ser_nbits = min(remaining, DATA_WIDTH) and ser_last = (remaining <= DATA_WIDTH), go SHIFT.
REQ-026 SHIFT: wait for ser_word_done; on it subtract ser_nbits from remaining; if ser_last then pulse frame_done and go GAP, else go FETCH.
REQ-027 Word-to-word latency SHALL be 2 cycles from ser_word_done to next ser_valid.
REQ-028 GAP: count IFS_CYCLES cycles, then IDLE; requests are not granted during GAP.
REQ-029 abort in FETCH/LOAD/SHIFT SHALL go GAP next cycle without frame_done; any rd strobe already issued is not repeated; abort in IDLE/GAP has no effect.
REQ-030 ser_word_done outside SHIFT SHALL be ignored.
REQ-031 remaining-bit arithmetic SHALL be SIZE_WIDTH unsigned, never underflowing below 0.
REQ-032 ser_data SHALL hold its value between ser_valid pulses; nbits, last likewise.

Reset
REQ-033 On reset low: state IDLE, all strobes/pulses 0, ser_data 0, ser_nbits 0, ser_last 0, busy 0, owner 0, ctrl_run 0, counters 0; effective mid-frame immediately, no frame_done.

Structure
REQ-034 FSM state encodings and the owner encoding SHALL live in the shared wifi TX package.
REQ-035 Arbitration SHALL be a sub-module wifi_tx_sched_arbiter (inputs reqs, ctrl_run; output winner); the rest is a single module.

Verification
REQ-036 req_ctrl, size 80 -> gnt_ctrl; three ser_valid with nbits 32,32,16, ser_last on third; frame_done one cycle after third ser_word_done.
REQ-037 req_ctrl and req_data both held, MAX_CTRL_RUN=4 -> grant order ctrl x4, data, ctrl...
REQ-038 size 32 -> single ser_valid, nbits 32, ser_last 1; size 0 -> gnt then frame_done, no ser_valid.
REQ-039 abort during SHIFT of word 2 of a 96-bit frame -> no frame_done, busy holds IFS_CYCLES then IDLE, no further rd strobe.
REQ-040 reset asserted in SHIFT -> all outputs 0 asynchronously; after release, pending request granted normally.
REQ-041 spurious ser_word_done in IDLE and FETCH -> no state change, no counter change.
